// File: rtl/control_fsm.sv
// Multicycle control unit for the teaching processor: Init/Fetch/Decode plus execute
// states, with an internal instruction register and a configurable load wait.
module control_fsm #(
   parameter int D_ADDR_W  = 8,
   parameter int RF_ADDR_W = 4,
   parameter int ALU_SEL_W = 3,
   parameter int PC_W      = 7,
   parameter int LOAD_WAIT = 1,
   localparam int IW       = 4 + D_ADDR_W + RF_ADDR_W
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [IW-1:0]        IR_in,
   input  logic                 Resume,
   output logic [IW-1:0]        IR,
   output logic                 PC_clr,
   output logic                 PC_up,
   output logic                 PC_ld,
   output logic [PC_W-1:0]      PC_target,
   output logic                 IR_ld,
   output logic [D_ADDR_W-1:0]  D_Addr,
   output logic                 D_Wr,
   output logic                 RF_s,
   output logic                 RF_W_en,
   output logic [RF_ADDR_W-1:0] RF_W_addr,
   output logic [RF_ADDR_W-1:0] RF_Ra_addr,
   output logic [RF_ADDR_W-1:0] RF_Rb_addr,
   output logic [ALU_SEL_W-1:0] Alu_s0,
   output logic                 Halted,
   output logic                 Illegal,
   output logic [3:0]           StateOut
);

   localparam int CNT_W = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
   localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_WAIT - 1);

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;
   localparam logic [3:0] OP_JMP   = 4'd6;
   localparam logic [3:0] OP_AND   = 4'd7;
   localparam logic [3:0] OP_OR    = 4'd8;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_STORE  = 4'd4,
      S_LOADA  = 4'd5,
      S_LOADB  = 4'd6,
      S_ALU    = 4'd7,
      S_JMP    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   state_t               state_reg, state_next;
   logic [IW-1:0]        ir_reg;
   logic [CNT_W-1:0]     wait_cnt_reg, wait_cnt_next;

   logic [3:0]           opcode;
   logic [RF_ADDR_W-1:0] a_field, b_field, w_field;
   logic [D_ADDR_W-1:0]  da_hi, da_lo;

   assign opcode  = ir_reg[IW-1 -: 4];
   assign a_field = ir_reg[IW-5 -: RF_ADDR_W];
   assign b_field = ir_reg[IW-5-RF_ADDR_W -: RF_ADDR_W];
   assign w_field = ir_reg[RF_ADDR_W-1:0];
   assign da_hi   = ir_reg[IW-5 -: D_ADDR_W];
   assign da_lo   = ir_reg[D_ADDR_W-1:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg    <= S_INIT;
         ir_reg       <= '0;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (state_reg == S_FETCH) begin
            ir_reg <= IR_in;
         end
      end
   end

   always_comb begin
      state_next    = S_FETCH;
      wait_cnt_next = wait_cnt_reg;
      case (state_reg)
         S_INIT:  state_next = S_FETCH;
         S_FETCH: state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_STORE: state_next = S_STORE;
               OP_LOAD: begin
                  state_next    = S_LOADA;
                  wait_cnt_next = LOAD_CNT;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_ALU;
               OP_HALT: state_next = S_HALT;
               OP_JMP:  state_next = S_JMP;
               default: state_next = S_NOOP;
            endcase
         end
         S_LOADA: begin
            if (wait_cnt_reg == '0) begin
               state_next = S_LOADB;
            end else begin
               state_next    = S_LOADA;
               wait_cnt_next = wait_cnt_reg - CNT_W'(1);
            end
         end
         S_HALT:  state_next = Resume ? S_FETCH : S_HALT;
         // Single-cycle execute states and any unreachable code return to Fetch
         default: state_next = S_FETCH;
      endcase
   end

   always_comb begin
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      PC_ld      = 1'b0;
      PC_target  = '0;
      IR_ld      = 1'b0;
      D_Addr     = '0;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_en    = 1'b0;
      RF_W_addr  = '0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      Alu_s0     = '0;
      Halted     = 1'b0;
      Illegal    = 1'b0;
      case (state_reg)
         S_INIT: PC_clr = 1'b1;
         S_FETCH: begin
            IR_ld = 1'b1;
            PC_up = 1'b1;
         end
         S_DECODE: Illegal = (opcode > OP_OR);
         S_STORE: begin
            D_Addr     = da_lo;
            D_Wr       = 1'b1;
            RF_Ra_addr = a_field;
         end
         S_LOADA, S_LOADB: begin
            D_Addr    = da_hi;
            RF_s      = 1'b1;
            RF_W_addr = w_field;
            RF_W_en   = (state_reg == S_LOADB);
         end
         S_ALU: begin
            RF_Ra_addr = a_field;
            RF_Rb_addr = b_field;
            RF_W_addr  = w_field;
            RF_W_en    = 1'b1;
            case (opcode)
               OP_ADD:  Alu_s0 = ALU_SEL_W'(1);
               OP_SUB:  Alu_s0 = ALU_SEL_W'(2);
               OP_AND:  Alu_s0 = ALU_SEL_W'(3);
               OP_OR:   Alu_s0 = ALU_SEL_W'(4);
               default: Alu_s0 = '0;
            endcase
         end
         S_JMP: begin
            PC_ld     = 1'b1;
            PC_target = ir_reg[PC_W-1:0];
         end
         S_HALT: Halted = 1'b1;
         default: ;
      endcase
   end

   assign IR       = ir_reg;
   assign StateOut = state_reg;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-cycle expected-output tables fed through a scoreboard,
// run on a LOAD_WAIT=1 and a LOAD_WAIT=3 instance, plus hand-written reset cases.
module tb_control_fsm;

   typedef struct packed {
      logic       pc_clr, pc_up, pc_ld, ir_ld, d_wr, rf_s, rf_w_en, halted, illegal;
      logic [7:0] d_addr;
      logic [3:0] wa, ra, rb;
      logic [2:0] alu;
   } outs_t;

   typedef struct {
      bit          which;
      logic [15:0] ir;
      logic        res;
      outs_t       exp;
      logic [6:0]  pt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_a, rst_b, resume;
   logic [15:0] ir_in;

   logic [15:0] ir_a, ir_b;
   logic pc_clr_a, pc_up_a, pc_ld_a, ir_ld_a, d_wr_a, rf_s_a, rf_w_en_a, halted_a, illegal_a;
   logic pc_clr_b, pc_up_b, pc_ld_b, ir_ld_b, d_wr_b, rf_s_b, rf_w_en_b, halted_b, illegal_b;
   logic [6:0] pt_a, pt_b;
   logic [7:0] d_addr_a, d_addr_b;
   logic [3:0] wa_a, ra_a, rb_a, wa_b, ra_b, rb_b, st_a, st_b;
   logic [2:0] alu_a, alu_b;

   int tests = 0;
   int fails = 0;
   vec_t vecs_a[$];
   vec_t vecs_b[$];
   vec_t sb[$];

   always #5 clk = ~clk;

   control_fsm dut_a (
      .Clk(clk), .Reset(rst_a), .IR_in(ir_in), .Resume(resume), .IR(ir_a),
      .PC_clr(pc_clr_a), .PC_up(pc_up_a), .PC_ld(pc_ld_a), .PC_target(pt_a),
      .IR_ld(ir_ld_a), .D_Addr(d_addr_a), .D_Wr(d_wr_a), .RF_s(rf_s_a),
      .RF_W_en(rf_w_en_a), .RF_W_addr(wa_a), .RF_Ra_addr(ra_a), .RF_Rb_addr(rb_a),
      .Alu_s0(alu_a), .Halted(halted_a), .Illegal(illegal_a), .StateOut(st_a)
   );

   control_fsm #(.LOAD_WAIT(3)) dut_b (
      .Clk(clk), .Reset(rst_b), .IR_in(ir_in), .Resume(resume), .IR(ir_b),
      .PC_clr(pc_clr_b), .PC_up(pc_up_b), .PC_ld(pc_ld_b), .PC_target(pt_b),
      .IR_ld(ir_ld_b), .D_Addr(d_addr_b), .D_Wr(d_wr_b), .RF_s(rf_s_b),
      .RF_W_en(rf_w_en_b), .RF_W_addr(wa_b), .RF_Ra_addr(ra_b), .RF_Rb_addr(rb_b),
      .Alu_s0(alu_b), .Halted(halted_b), .Illegal(illegal_b), .StateOut(st_b)
   );

   function automatic outs_t samp(input bit which);
      if (!which)
         return {pc_clr_a, pc_up_a, pc_ld_a, ir_ld_a, d_wr_a, rf_s_a, rf_w_en_a, halted_a,
                 illegal_a, d_addr_a, wa_a, ra_a, rb_a, alu_a};
      return {pc_clr_b, pc_up_b, pc_ld_b, ir_ld_b, d_wr_b, rf_s_b, rf_w_en_b, halted_b,
              illegal_b, d_addr_b, wa_b, ra_b, rb_b, alu_b};
   endfunction

   function automatic outs_t o_init();
      outs_t o = '0;
      o.pc_clr = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_fetch();
      outs_t o = '0;
      o.pc_up = 1'b1;
      o.ir_ld = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_dec(input logic ill);
      outs_t o = '0;
      o.illegal = ill;
      return o;
   endfunction

   function automatic outs_t o_store(input logic [7:0] a, input logic [3:0] ra);
      outs_t o = '0;
      o.d_addr = a;
      o.d_wr   = 1'b1;
      o.ra     = ra;
      return o;
   endfunction

   function automatic outs_t o_load(input logic [7:0] a, input logic [3:0] wa, input logic wen);
      outs_t o = '0;
      o.d_addr  = a;
      o.rf_s    = 1'b1;
      o.wa      = wa;
      o.rf_w_en = wen;
      return o;
   endfunction

   function automatic outs_t o_alu(input logic [3:0] ra, rb, wa, input logic [2:0] sel);
      outs_t o = '0;
      o.ra      = ra;
      o.rb      = rb;
      o.wa      = wa;
      o.rf_w_en = 1'b1;
      o.alu     = sel;
      return o;
   endfunction

   function automatic outs_t o_jmp();
      outs_t o = '0;
      o.pc_ld = 1'b1;
      return o;
   endfunction

   function automatic outs_t o_halt();
      outs_t o = '0;
      o.halted = 1'b1;
      return o;
   endfunction

   task automatic add(input bit w, input logic [15:0] ir, input logic res, input outs_t e,
                      input logic [6:0] pt);
      vec_t v;
      v.which = w; v.ir = ir; v.res = res; v.exp = e; v.pt = pt;
      if (w) vecs_b.push_back(v);
      else vecs_a.push_back(v);
   endtask

   task automatic build();
      logic [15:0] alu_ir[4];
      logic [2:0]  alu_sel[4];
      alu_ir[0] = 16'h3123; alu_sel[0] = 3'd1;
      alu_ir[1] = 16'h4123; alu_sel[1] = 3'd2;
      alu_ir[2] = 16'h7123; alu_sel[2] = 3'd3;
      alu_ir[3] = 16'h8123; alu_sel[3] = 3'd4;
      // NOOP then LOAD 0x21B5
      add(0, 16'h0000, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(0), 0);
      add(0, 16'h0000, 0, '0, 0);
      add(0, 16'h21B5, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(0), 0);
      add(0, 16'h0000, 0, o_load(8'h1B, 4'd5, 0), 0);
      add(0, 16'h0000, 0, o_load(8'h1B, 4'd5, 1), 0);
      // STORE
      add(0, 16'h132A, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(0), 0);
      add(0, 16'h0000, 0, o_store(8'h2A, 4'd3), 0);
      for (int k = 0; k < 4; k++) begin
         add(0, alu_ir[k], 0, o_fetch(), 0);
         add(0, 16'h0000, 0, o_dec(0), 0);
         add(0, 16'h0000, 0, o_alu(4'd1, 4'd2, 4'd3, alu_sel[k]), 0);
      end
      // JMP
      add(0, 16'h6012, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(0), 0);
      add(0, 16'h0000, 0, o_jmp(), 7'h12);
      // illegal opcodes behave as NOOP
      add(0, 16'hF000, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(1), 0);
      add(0, 16'h0000, 0, '0, 0);
      add(0, 16'h9ABC, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(1), 0);
      add(0, 16'h0000, 0, '0, 0);
      // HALT with Resume high outside Halt, then held, then resumed
      add(0, 16'h5000, 1, o_fetch(), 0);
      add(0, 16'h0000, 1, o_dec(0), 0);
      for (int k = 0; k < 10; k++) add(0, 16'h0000, 0, o_halt(), 0);
      add(0, 16'h0000, 1, o_halt(), 0);
      add(0, 16'h0000, 0, o_fetch(), 0);
      add(0, 16'h0000, 0, o_dec(0), 0);
      add(0, 16'h0000, 0, '0, 0);
      // LOAD_WAIT=3 instance
      add(1, 16'h21B5, 0, o_fetch(), 0);
      add(1, 16'h0000, 0, o_dec(0), 0);
      for (int k = 0; k < 3; k++) add(1, 16'h0000, 0, o_load(8'h1B, 4'd5, 0), 0);
      add(1, 16'h0000, 0, o_load(8'h1B, 4'd5, 1), 0);
      add(1, 16'h0000, 0, o_fetch(), 0);
      add(1, 16'h0000, 0, o_dec(0), 0);
      add(1, 16'h0000, 0, '0, 0);
   endtask

   task automatic apply(input vec_t v);
      @(posedge clk);
      #1;
      ir_in  = v.ir;
      resume = v.res;
      sb.push_back(v);
   endtask

   task automatic push_init(input bit w);
      vec_t v;
      v.which = w; v.ir = 16'h0; v.res = 1'b0; v.exp = o_init(); v.pt = 7'h0;
      sb.push_back(v);
   endtask

   task automatic chk_init(input bit w, input string name);
      outs_t got;
      logic [15:0] irv;
      got = samp(w);
      irv = w ? ir_b : ir_a;
      tests++;
      if (got !== o_init()) begin
         fails++;
         $display("FAIL %s dut%0d outputs: got %h expected %h", name, w, got, o_init());
      end
      tests++;
      if (irv !== 16'h0) begin
         fails++;
         $display("FAIL %s dut%0d IR: got %h expected 0000", name, w, irv);
      end
   endtask

   always @(negedge clk) begin : mon
      vec_t  e;
      outs_t got;
      logic [6:0] ptv;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         got = samp(e.which);
         tests++;
         if (got !== e.exp) begin
            fails++;
            $display("FAIL cycle dut%0d ir=%h: got %h expected %h", e.which, e.ir, got, e.exp);
         end else begin
            $display("[TB] dut%0d ir=%h outputs %h ok", e.which, e.ir, got);
         end
         if (e.exp.pc_ld) begin
            ptv = e.which ? pt_b : pt_a;
            tests++;
            if (ptv !== e.pt) begin
               fails++;
               $display("FAIL pc_target dut%0d: got %h expected %h", e.which, ptv, e.pt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      ir_in = 16'h0; resume = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
      build();
      #2 rst_a = 1'b1; rst_b = 1'b1;
      #1 chk_init(0, "async_reset");
      chk_init(1, "async_reset");
      repeat (2) @(posedge clk);
      #1 rst_a = 1'b0;
      push_init(0);
      foreach (vecs_a[i]) apply(vecs_a[i]);

      @(posedge clk);
      #1 rst_a = 1'b1; rst_b = 1'b0;
      push_init(1);
      foreach (vecs_b[i]) apply(vecs_b[i]);

      // Reset in the second LoadA cycle must abort the load without a write
      apply(vecs_b[0]);
      apply(vecs_b[1]);
      apply(vecs_b[2]);
      apply(vecs_b[3]);
      @(negedge clk);
      #1 rst_b = 1'b1;
      #1 chk_init(1, "mid_load_reset");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_init(1, "held_reset");
      end
      @(posedge clk);
      #1 rst_b = 1'b0;
      push_init(1);
      apply(vecs_b[0]);
      apply(vecs_b[1]);
      apply(vecs_b[2]);
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
